br_resolve_unit: RTL

//  EX-stage consumer of IF branch predictions: queues each predicted branch from fetch and evaluates
//  the BEQ/BNE condition in EX. Drives IS_BR_EX/BRANCH_EX back to the IF predictor, and on a

---
 rtl/br_resolve_unit_pkg.sv | 34 +++
 rtl/br_resolve_unit_if.sv | 33 +++
 rtl/br_resolve_unit_pred_fifo.sv | 61 ++++++
 rtl/br_resolve_unit.sv | 137 +++++++++++++
 4 files changed

// File: rtl/br_resolve_unit_pkg.sv
// Shared types for the branch resolve unit: opcodes, flush FSM encoding, queued prediction entry.
package br_pkg;

  localparam logic [5:0] OP_BEQ = 6'b101000;
  localparam logic [5:0] OP_BNE = 6'b101001;

  typedef enum logic {
    IDLE     = 1'b0,
    FLUSHING = 1'b1
  } br_state_e;

  typedef struct packed {
    logic        pred_taken;
    logic [31:0] pc_4;
    logic [31:0] target;
  } br_entry_t;

  function automatic logic br_is_legal(input logic [5:0] op);
    return (op == OP_BEQ) || (op == OP_BNE);
  endfunction

  // BNE is the inverse of the equality compare; anything else resolves not-taken.
  function automatic logic br_outcome(input logic [5:0] op, input logic [31:0] rs,
                                      input logic [31:0] rt);
    logic taken;
    case (op)
      OP_BEQ:  taken = (rs == rt);
      OP_BNE:  taken = (rs != rt);
      default: taken = 1'b0;
    endcase
    return taken;
  endfunction

endpackage

// File: rtl/br_resolve_unit_if.sv
// Bundle of the IF push channel, the EX resolve channel and the unit's feedback outputs.
interface br_resolve_unit_if;

  logic        push_valid;
  logic        push_pred_taken;
  logic [31:0] push_pc_4;
  logic [31:0] push_target;
  logic        ex_valid;
  logic [5:0]  ex_op;
  logic [31:0] ex_rs;
  logic [31:0] ex_rt;
  logic        is_br_ex;
  logic        branch_ex;
  logic        flush;
  logic [31:0] redirect_pc;
  logic        q_full;
  logic        err;
  logic [31:0] br_total;
  logic [31:0] br_miss;

  modport master (
    output push_valid, push_pred_taken, push_pc_4, push_target,
    output ex_valid, ex_op, ex_rs, ex_rt,
    input  is_br_ex, branch_ex, flush, redirect_pc, q_full, err, br_total, br_miss
  );

  modport slave (
    input  push_valid, push_pred_taken, push_pc_4, push_target,
    input  ex_valid, ex_op, ex_rs, ex_rt,
    output is_br_ex, branch_ex, flush, redirect_pc, q_full, err, br_total, br_miss
  );

endinterface

// File: rtl/br_resolve_unit_pred_fifo.sv
// Synchronous FIFO of pending branch predictions; clear empties it in one edge.
module br_pred_fifo
  import br_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      push,
  input  logic      pop,
  input  logic      clear,
  input  br_entry_t push_entry,
  output br_entry_t head,
  output logic      full,
  output logic      empty
);

  localparam int AW = $clog2(DEPTH);

  br_entry_t        mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [AW:0]      count_r;

  assign full  = (count_r == (AW+1)'(DEPTH));
  assign empty = (count_r == '0);
  assign head  = mem_r[rd_ptr_r];

  // Entry storage; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_r[wr_ptr_r] <= push_entry;
    end
  end

  // Pointers and occupancy; clear drops every entry including a same-cycle push.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else if (clear) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (push) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (pop) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      case ({push, pop})
        2'b10:   count_r <= count_r + (AW+1)'(1);
        2'b01:   count_r <= count_r - (AW+1)'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/br_resolve_unit.sv
// EX-stage branch resolver: checks queued IF predictions and flushes/redirects on mispredict.
// Optional statistics counters are built when BR_RESOLVE_STATS_EN is defined.
module br_resolve_unit
  import br_pkg::*;
#(
  parameter int DEPTH        = 4,
  parameter int FLUSH_CYCLES = 2
) (
  input logic               clk,
  input logic               rst_n,
  br_resolve_unit_if.slave  bus
);

  localparam int CW = $clog2(FLUSH_CYCLES) + 1;

  br_state_e   state_r, state_nx_s;
  logic [CW-1:0] cnt_r, cnt_nx_s;
  logic        flush_r, flush_nx_s;
  logic [31:0] redirect_r, redirect_nx_s;
  logic        err_r;

  br_entry_t   head_s, push_entry_s;
  logic        full_s, empty_s;
  logic        idle_s, legal_s, outcome_s, resolve_s;
  logic        mispredict_s, pop_s, push_s, err_set_s;

  br_pred_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (push_s),
    .pop        (pop_s),
    .clear      (mispredict_s),
    .push_entry (push_entry_s),
    .head       (head_s),
    .full       (full_s),
    .empty      (empty_s)
  );

  // Resolve datapath; an empty queue reads as a not-taken prediction and never flushes.
  always_comb begin
    idle_s       = (state_r == IDLE);
    legal_s      = br_is_legal(bus.ex_op);
    outcome_s    = br_outcome(bus.ex_op, bus.ex_rs, bus.ex_rt);
    resolve_s    = idle_s & bus.ex_valid & legal_s;
    mispredict_s = resolve_s & ~empty_s & (head_s.pred_taken ^ outcome_s);
    pop_s        = resolve_s & ~empty_s;
    push_s       = idle_s & bus.push_valid & (~full_s | pop_s) & ~mispredict_s;
    err_set_s    = idle_s & bus.ex_valid & (~legal_s | empty_s);
    push_entry_s = '{pred_taken: bus.push_pred_taken,
                     pc_4:       bus.push_pc_4,
                     target:     bus.push_target};
  end

  // Flush FSM state register plus the registered flush/redirect/error outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      cnt_r      <= '0;
      flush_r    <= 1'b0;
      redirect_r <= 32'h0000_0000;
      err_r      <= 1'b0;
    end else begin
      state_r    <= state_nx_s;
      cnt_r      <= cnt_nx_s;
      flush_r    <= flush_nx_s;
      redirect_r <= redirect_nx_s;
      err_r      <= err_r | err_set_s;
    end
  end

  // Next-state logic: hold FLUSHING for exactly FLUSH_CYCLES cycles.
  always_comb begin
    state_nx_s = state_r;
    cnt_nx_s   = cnt_r;
    case (state_r)
      IDLE: begin
        if (mispredict_s) begin
          state_nx_s = FLUSHING;
          cnt_nx_s   = CW'(FLUSH_CYCLES - 1);
        end else begin
          state_nx_s = IDLE;
        end
      end
      FLUSHING: begin
        if (cnt_r == '0) begin
          state_nx_s = IDLE;
        end else begin
          cnt_nx_s = cnt_r - CW'(1);
        end
      end
      default: begin
        state_nx_s = IDLE;
        cnt_nx_s   = '0;
      end
    endcase
  end

  // Output decode for the next cycle; redirect latches the actual-path PC.
  always_comb begin
    flush_nx_s = (state_nx_s == FLUSHING);
    if (mispredict_s) begin
      redirect_nx_s = outcome_s ? head_s.target : head_s.pc_4;
    end else begin
      redirect_nx_s = redirect_r;
    end
  end

  assign bus.is_br_ex    = resolve_s;
  assign bus.branch_ex   = resolve_s & outcome_s;
  assign bus.flush       = flush_r;
  assign bus.redirect_pc = redirect_r;
  assign bus.q_full      = full_s;
  assign bus.err         = err_r;

`ifdef BR_RESOLVE_STATS_EN
  logic [31:0] total_r;
  logic [31:0] miss_r;

  // Statistics counters, free-running modulo 2^32.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      total_r <= 32'h0000_0000;
      miss_r  <= 32'h0000_0000;
    end else begin
      total_r <= total_r + {31'h0, resolve_s};
      miss_r  <= miss_r + {31'h0, mispredict_s};
    end
  end

  assign bus.br_total = total_r;
  assign bus.br_miss  = miss_r;
`else
  assign bus.br_total = 32'h0000_0000;
  assign bus.br_miss  = 32'h0000_0000;
`endif

endmodule
